// File: rtl/booth_radix4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands.
// Optional debug taps enabled with `define BOOTH_RADIX4_DEBUG_EN.
module booth_radix4_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   mpd,
  input  logic [WIDTH-1:0]   mpr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] res
`ifdef BOOTH_RADIX4_DEBUG_EN
  ,
  output logic [WIDTH-1:0]   dbg_cnt,
  output logic [2*WIDTH+4:0] dbg_p
`endif
);

  localparam int EW = WIDTH + 2;
  localparam int PW = 2 * WIDTH + 5;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH / 2 + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] cnt;
  logic [PW-1:0]    p;
  logic [EW-1:0]    m;

  logic [EW-1:0]        dm;
  logic signed [PW-1:0] p_sum;
  logic [PW-1:0]        p_nxt;
  logic [EW-1:0]        mpd_x;
  logic [EW-1:0]        mpr_x;

  assign mpd_x = {{2{signed_mode & mpd[WIDTH-1]}}, mpd};
  assign mpr_x = {{2{signed_mode & mpr[WIDTH-1]}}, mpr};

  // Digit multiple kept to EW bits; the bounded accumulator never needs more.
  always_comb begin
    dm = '0;
    unique case (p[2:0])
      3'b001, 3'b010: dm = m;
      3'b011:         dm = {m[EW-2:0], 1'b0};
      3'b100:         dm = -{m[EW-2:0], 1'b0};
      3'b101, 3'b110: dm = -m;
      default:        dm = '0;
    endcase
  end

  // Accumulate above the multiplier window, then shift two bits per digit.
  always_comb begin
    p_sum = $signed(p + {dm, {(PW - EW){1'b0}}});
    p_nxt = p_sum >>> 2;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= '0;
      m     <= '0;
      res   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= mpd_x;
            p     <= {{EW{1'b0}}, mpr_x, 1'b0};
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          if (cnt == LAST) begin
            res   <= p[2*WIDTH:1];
            state <= DONE;
          end else begin
            p   <= p_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

`ifdef BOOTH_RADIX4_DEBUG_EN
  assign dbg_cnt = cnt;
  assign dbg_p   = p;
`endif

endmodule

// File: tb/tb_booth_radix4_mult.sv
// Scoreboard bench for booth_radix4_mult: directed corners plus
// random operations against an integer-product reference.
module tb_booth_radix4_mult;

  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic           signed_mode;
  logic [W-1:0]   mpd;
  logic [W-1:0]   mpr;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] res;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit bp = 1'b0;
  logic ov_d = 1'b0;
  logic [2*W-1:0] last_exp = '0;
  logic [2*W-1:0] exp_q[$];

  booth_radix4_mult #(.WIDTH(W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .signed_mode(signed_mode),
    .mpd        (mpd),
    .mpr        (mpr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .res        (res)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(logic [W-1:0] a,
                                             logic [W-1:0] b,
                                             logic sm);
    longint x;
    longint y;
    longint z;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    z = x * y;
    return z[2*W-1:0];
  endfunction

  // Monitor: one comparison per completed output handshake.
  always @(negedge clock) begin
    if (reset) begin
      ov_d <= 1'b0;
    end else begin
      if (out_valid && !ov_d)
        chk("latency", cyc - last_acc, 6);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else chk("res", {16'h0, res}, {16'h0, exp_q.pop_front()});
      end
      ov_d <= out_valid;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(logic [W-1:0] a, logic [W-1:0] b, logic sm);
    int t = 0;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    mpd = a;
    mpr = b;
    signed_mode = sm;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    last_acc = cyc;
    in_valid = 1'b0;
    last_exp = ref_mul(a, b, sm);
    exp_q.push_back(last_exp);
    if (bp) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      step();
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    int t;
    int seen;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    signed_mode = 1'b0;
    mpd = '0;
    mpr = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    reset = 1'b0;

    issue(8'h80, 8'h80, 1'b1);
    drain();
    chk("valid_one_cycle", out_valid, 0);
    chk("idle_after_hs", in_ready, 1);
    chk("res_kept", res, last_exp);
    issue(8'hFF, 8'hFF, 1'b0);
    drain();
    issue(8'hFF, 8'h05, 1'b1);
    drain();

    out_ready = 1'b0;
    issue(8'h7F, 8'h81, 1'b1);
    t = 0;
    while (!out_valid && t < 20) begin
      step();
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_res", res, last_exp);
      chk("hold_in_ready", in_ready, 0);
      in_valid = 1'b1;
      mpd = 8'($urandom);
      mpr = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("hold_release", in_ready, 1);
    chk("hold_drained", exp_q.size(), 0);

    issue(8'h12, 8'hE4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      mpd = 8'($urandom);
      mpr = 8'($urandom);
      signed_mode = ~signed_mode;
      step();
    end
    in_valid = 1'b0;
    drain();

    issue(8'h55, 8'h9A, 1'b1);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    chk("abort_res", res, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("abort_no_valid", seen, 0);
    issue(8'h03, 8'h04, 1'b0);
    drain();
    chk("after_abort_res", res, 16'h000C);

    bp = 1'b1;
    repeat (2000) issue(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    drain();
    bp = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
